// File: rtl/dmem_ctrl.sv
// Data memory controller: fills memory with its own indices after reset, then serves
// pipelined LOAD/STORE/LOADI requests with a fixed load response latency.
module dmem_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rdata,
   output logic              init_done
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam logic [3:0] OpLoad  = 4'b1101;
   localparam logic [3:0] OpStore = 4'b1110;
   localparam logic [3:0] OpLoadi = 4'b1111;

   typedef enum logic {StInit, StRun} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] init_cnt_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [RD_LAT-1:0] pipe_v_q;
   logic [DATA_W-1:0] pipe_d_q [RD_LAT];

   logic              accept;
   logic              resp_v;
   logic [DATA_W-1:0] resp_d;

   assign accept    = req_valid && (state_q == StRun);
   assign resp_v    = accept && ((op == OpLoad) || (op == OpLoadi));
   assign req_ready = (state_q == StRun);
   assign init_done = (state_q == StRun);
   assign rd_valid  = pipe_v_q[RD_LAT-1];
   assign rdata     = pipe_d_q[RD_LAT-1];

   // Load reads the array before the same-edge store lands (non-blocking write below).
   always_comb begin
      resp_d = DATA_W'(addr);
      if (op == OpLoad) begin
         resp_d = mem[addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
      end else begin
         case (state_q)
            StInit: begin
               if (&init_cnt_q) begin
                  state_q <= StRun;
               end else begin
                  init_cnt_q <= init_cnt_q + 1'b1;
               end
            end
            StRun:   state_q <= StRun;
            default: state_q <= StInit;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == StInit) begin
         mem[init_cnt_q] <= DATA_W'(init_cnt_q);
      end else if (accept && (op == OpStore)) begin
         mem[addr] <= wdata;
      end
   end

   // Each stage keeps its data when idle so the last stage doubles as the held rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_d_q[i] <= '0;
         end
      end else begin
         pipe_v_q[0] <= resp_v;
         if (resp_v) begin
            pipe_d_q[0] <= resp_d;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            if (pipe_v_q[i-1]) begin
               pipe_d_q[i] <= pipe_d_q[i-1];
            end
         end
      end
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width (2..32).
REQ-002 SHALL have parameter ADDR_W, default 8, address width; depth DEPTH = 2**ADDR_W words (4..12).
REQ-003 SHALL have parameter RD_LAT, default 1, load response latency in cycles (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port op  input  4  opcode: 4'b1101 LOAD, 4'b1110 STORE, 4'b1111 LOADI; all others NOP.
REQ-009 SHALL have port addr  input  ADDR_W  word address, or immediate for LOADI.
REQ-010 SHALL have port wdata  input  DATA_W  store data.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse marking rdata as new.
REQ-012 SHALL have port rdata  output  DATA_W  load/LOADI result; holds last value between pulses.
REQ-013 SHALL have port init_done  output  1  memory initialisation complete.

Function
REQ-014 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT.
REQ-015 In INIT, SHALL write mem[i] = i truncated/zero-extended to DATA_W, one word per cycle, i = 0..DEPTH-1, starting the first cycle after rst_n deasserts.
REQ-016 SHALL move INIT->RUN on the cycle after writing index DEPTH-1; init_done rises then and stays 1 until reset (INIT lasts exactly DEPTH cycles).
REQ-017 req_ready SHALL be 0 in INIT and 1 in RUN; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-018 In RUN, SHALL accept one request per cycle with no back-pressure (fully pipelined).
REQ-019 Accepted STORE SHALL write wdata to mem[addr] at the accepting edge; no response.
REQ-020 Accepted LOAD SHALL sample mem[addr] as it stands before any write at the same edge; rdata/rd_valid appear exactly RD_LAT cycles after acceptance.
REQ-021 Accepted LOADI SHALL return addr zero-extended (or truncated) to DATA_W with the same RD_LAT latency as LOAD.
REQ-022 Accepted NOP SHALL change no memory and produce no rd_valid.
REQ-023 Responses SHALL return in request order; back-to-back loads SHALL produce back-to-back rd_valid pulses.
REQ-024 STORE accepted at cycle N followed by LOAD of the same address at N+1 SHALL return the stored data (no stale read).
REQ-025 Address arithmetic SHALL be unsigned; the INIT counter SHALL not wrap past DEPTH-1.
REQ-026 rd_valid SHALL be 0 while in INIT; requests offered during INIT SHALL be ignored and not queued.

Reset
REQ-027 On rst_n low, SHALL immediately force req_ready=0, rd_valid=0, rdata=0, init_done=0, state=INIT, INIT counter=0, and clear all RD_LAT pipeline stages.
REQ-028 Reset mid-operation SHALL discard in-flight loads (no late rd_valid) and, after deassertion, re-run the full INIT fill overwriting all prior contents.
REQ-029 Memory contents SHALL be undefined only during reset and INIT; after init_done they equal REQ-015 values.

Verification
REQ-030 Defaults, release rst_n -> req_ready=0 for 256 cycles, then init_done=1, req_ready=1; LOAD addr 8'h5A -> rd_valid 1 cycle later, rdata=8'h5A.
REQ-031 STORE addr 8'h10 wdata 8'hC3 at cycle N, LOAD 8'h10 at N+1 -> rdata=8'hC3 at N+1+RD_LAT; LOAD 8'h11 -> 8'h11.
REQ-032 RD_LAT=3, four consecutive LOADs addr 1,2,3,4 -> rd_valid high four consecutive cycles starting 3 cycles after first accept, rdata 1,2,3,4 in order.
REQ-033 LOADI addr 8'hFF, then op 4'b0000 -> rdata=8'hFF one rd_valid pulse; NOP gives no pulse and rdata holds 8'hFF.
REQ-034 RD_LAT=2, LOAD accepted then rst_n pulsed low next cycle -> no rd_valid ever for it, rdata=0, INIT restarts; earlier STORE of 8'hC3 to 8'h10 reads back 8'h10 after init_done.
REQ-035 DATA_W=16, ADDR_W=4 -> INIT 16 cycles; LOAD addr 4'hF -> rdata=16'h000F; req_valid asserted during INIT -> no response, no memory change.
